// File: rtl/seq_detect_event_logger.sv
// Observes the four-in-a-row detector (z, present_state) and logs zeros-/ones-run events
// into wrapping BCD counters with sticky flags; SEQ_LOG_STRETCH_EN enables the LED stretch counter.
module seq_detect_event_logger #(
  parameter int unsigned STRETCH = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       z,
  input  logic [3:0] present_state,
  output logic [7:0] zeros_count,
  output logic [7:0] ones_count,
  output logic       last_kind,
  output logic       event_led,
  output logic       overflow,
  output logic       state_err
);

  localparam logic [3:0] STATE_ZEROS = 4'd4;
  localparam logic [3:0] STATE_ONES  = 4'd8;
  localparam logic [7:0] STRETCH_LD  = 8'(STRETCH);

  logic       z_d;
  logic       event_hit;
  logic       is_zeros;
  logic       is_ones;
  logic [7:0] zeros_next;
  logic [7:0] ones_next;

  // BCD increment of a {tens, ones} byte; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  assign event_hit  = z & ~z_d;
  assign is_zeros   = (present_state == STATE_ZEROS);
  assign is_ones    = (present_state == STATE_ONES);
  assign zeros_next = bcd_inc(zeros_count);
  assign ones_next  = bcd_inc(ones_count);

  // z_d resets high so a z already asserted at reset release is not an event.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      z_d         <= 1'b1;
      zeros_count <= 8'h00;
      ones_count  <= 8'h00;
      last_kind   <= 1'b0;
      overflow    <= 1'b0;
      state_err   <= 1'b0;
    end else begin
      z_d <= z;
      if (Clear) begin
        zeros_count <= 8'h00;
        ones_count  <= 8'h00;
        last_kind   <= 1'b0;
        overflow    <= 1'b0;
        state_err   <= 1'b0;
      end else if (event_hit) begin
        if (is_zeros) begin
          zeros_count <= zeros_next;
          last_kind   <= 1'b0;
          if (zeros_count == 8'h99) overflow <= 1'b1;
        end else if (is_ones) begin
          ones_count <= ones_next;
          last_kind  <= 1'b1;
          if (ones_count == 8'h99) overflow <= 1'b1;
        end else begin
          state_err <= 1'b1;
        end
      end
    end
  end

`ifdef SEQ_LOG_STRETCH_EN
  logic [7:0] stretch_cnt;

  // Retrigger reloads rather than accumulates.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stretch_cnt <= 8'd0;
    end else if (Clear) begin
      stretch_cnt <= 8'd0;
    end else if (event_hit) begin
      stretch_cnt <= STRETCH_LD;
    end else if (stretch_cnt != 8'd0) begin
      stretch_cnt <= stretch_cnt - 8'd1;
    end
  end

  assign event_led = (stretch_cnt != 8'd0);
`else
  logic led_q;
  logic unused_stretch;

  assign unused_stretch = ^STRETCH_LD;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      led_q <= 1'b0;
    end else begin
      led_q <= event_hit & ~Clear;
    end
  end

  assign event_led = led_q;
`endif

endmodule

// File: tb/tb_seq_detect_event_logger.sv
// Directed bench for seq_detect_event_logger; LED-length expectations follow SEQ_LOG_STRETCH_EN.
module tb_seq_detect_event_logger;

  localparam int STRETCH = 8;
`ifdef SEQ_LOG_STRETCH_EN
  localparam int LED_LEN = STRETCH;
`else
  localparam int LED_LEN = 1;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Clear = 1'b0;
  logic       z = 1'b0;
  logic [3:0] present_state = 4'd0;
  logic [7:0] zeros_count;
  logic [7:0] ones_count;
  logic       last_kind;
  logic       event_led;
  logic       overflow;
  logic       state_err;

  int tests_run = 0;
  int tests_failed = 0;

  seq_detect_event_logger #(.STRETCH(STRETCH)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Clear(Clear),
    .z(z),
    .present_state(present_state),
    .zeros_count(zeros_count),
    .ones_count(ones_count),
    .last_kind(last_kind),
    .event_led(event_led),
    .overflow(overflow),
    .state_err(state_err)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One event of the given state followed by one low cycle.
  task automatic pulse_event(input logic [3:0] ps);
    z = 1'b1;
    present_state = ps;
    tick();
    z = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < STRETCH + 2; i++) tick();
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({zeros_count, ones_count, last_kind, event_led, overflow, state_err} !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got z=%h o=%h lk=%b led=%b ov=%b se=%b, want all 0",
               zeros_count, ones_count, last_kind, event_led, overflow, state_err);
    end
    z = 1'b1;
    present_state = 4'd8;
    tick();
    Reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (ones_count !== 8'h00 || event_led !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_z_high: got ones=%h led=%b, want 00 0", ones_count, event_led);
    end
    z = 1'b0;
    tick();
  endtask

  task automatic test_single_runs();
    int n;
    z = 1'b1;
    present_state = 4'd8;
    tick();
    tests_run++;
    if (ones_count !== 8'h01 || last_kind !== 1'b1 || event_led !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ones: got ones=%h lk=%b led=%b, want 01 1 1", ones_count, last_kind, event_led);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (event_led) n++;
      if (i == 4) z = 1'b0;
      tick();
    end
    tests_run++;
    if (n != LED_LEN || ones_count !== 8'h01) begin
      tests_failed++;
      $display("FAIL single_led_len: got len=%0d ones=%h, want %0d 01", n, ones_count, LED_LEN);
    end
    z = 1'b1;
    present_state = 4'd4;
    tick();
    tests_run++;
    if (zeros_count !== 8'h01 || last_kind !== 1'b0 || ones_count !== 8'h01) begin
      tests_failed++;
      $display("FAIL single_zeros: got zeros=%h lk=%b ones=%h, want 01 0 01", zeros_count, last_kind, ones_count);
    end
    z = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_stretch();
    z = 1'b1;
    present_state = 4'd8;
    tick();
    z = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if (event_led !== (LED_LEN > 3)) begin
      tests_failed++;
      $display("FAIL pre_reset_led: got %b, want %b", event_led, LED_LEN > 3);
    end
    Reset = 1'b1;
    #1;
    tests_run++;
    if ({zeros_count, ones_count, last_kind, event_led, overflow} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_stretch: got z=%h o=%h lk=%b led=%b ov=%b, want all 0",
               zeros_count, ones_count, last_kind, event_led, overflow);
    end
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_bcd_rollover();
    for (int i = 0; i < 9; i++) pulse_event(4'd8);
    tests_run++;
    if (ones_count !== 8'h09) begin
      tests_failed++;
      $display("FAIL bcd_9: got %h, want 09", ones_count);
    end
    pulse_event(4'd8);
    tests_run++;
    if (ones_count !== 8'h10 || zeros_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL bcd_10: got ones=%h zeros=%h, want 10 00", ones_count, zeros_count);
    end
    for (int i = 0; i < 89; i++) pulse_event(4'd8);
    tests_run++;
    if (ones_count !== 8'h99 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL bcd_99: got %h ov=%b, want 99 0", ones_count, overflow);
    end
    pulse_event(4'd8);
    tests_run++;
    if (ones_count !== 8'h00 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL bcd_wrap: got %h ov=%b, want 00 1", ones_count, overflow);
    end
    pulse_event(4'd8);
    tests_run++;
    if (ones_count !== 8'h01 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_sticky: got %h ov=%b, want 01 1", ones_count, overflow);
    end
    for (int i = 0; i < 10; i++) pulse_event(4'd4);
    tests_run++;
    if (zeros_count !== 8'h10 || ones_count !== 8'h01) begin
      tests_failed++;
      $display("FAIL zeros_carry: got zeros=%h ones=%h, want 10 01", zeros_count, ones_count);
    end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || ones_count !== 8'h00 || zeros_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL clear_flags: got ov=%b ones=%h zeros=%h, want 0 00 00", overflow, ones_count, zeros_count);
    end
    for (int i = 0; i < 99; i++) pulse_event(4'd8);
    Clear = 1'b1;
    z = 1'b1;
    present_state = 4'd8;
    tick();
    Clear = 1'b0;
    z = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || ones_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL wrap_clear: got ov=%b ones=%h, want 0 00", overflow, ones_count);
    end
    drain();
  endtask

  task automatic test_illegal_state();
    pulse_event(4'd8);
    drain();
    z = 1'b1;
    present_state = 4'd2;
    tick();
    tests_run++;
    if (ones_count !== 8'h01 || zeros_count !== 8'h00 || state_err !== 1'b1 ||
        event_led !== 1'b1 || last_kind !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_state: got ones=%h zeros=%h se=%b led=%b lk=%b, want 01 00 1 1 1",
               ones_count, zeros_count, state_err, event_led, last_kind);
    end
    z = 1'b0;
    drain();
    tests_run++;
    if (state_err !== 1'b1 || event_led !== 1'b0) begin
      tests_failed++;
      $display("FAIL state_err_sticky: got se=%b led=%b, want 1 0", state_err, event_led);
    end
  endtask

  task automatic test_clear_collision();
    int n;
    Clear = 1'b1;
    z = 1'b1;
    present_state = 4'd8;
    tick();
    Clear = 1'b0;
    tests_run++;
    if (ones_count !== 8'h00 || event_led !== 1'b0 || state_err !== 1'b0 || last_kind !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_collision: got ones=%h led=%b se=%b lk=%b, want 00 0 0 0",
               ones_count, event_led, state_err, last_kind);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (event_led || ones_count !== 8'h00) n++;
    end
    tests_run++;
    if (n != 0) begin
      tests_failed++;
      $display("FAIL clear_hold_z: got %0d cycles with led/count activity, want 0", n);
    end
    z = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    z = 1'b1;
    present_state = 4'd8;
    tick();
    z = 1'b0;
    tick();
    z = 1'b1;
    present_state = 4'd4;
    tick();
    z = 1'b0;
    tests_run++;
    if (ones_count !== 8'h01 || zeros_count !== 8'h01 || last_kind !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back: got ones=%h zeros=%h lk=%b, want 01 01 0", ones_count, zeros_count, last_kind);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (event_led) n++;
      tick();
    end
    tests_run++;
    if (n != LED_LEN) begin
      tests_failed++;
      $display("FAIL retrigger_len: got %0d, want %0d", n, LED_LEN);
    end
  endtask

  initial begin
    test_reset();
    test_single_runs();
    test_reset_mid_stretch();
    test_bcd_rollover();
    test_illegal_state();
    test_clear_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
